// File: rtl/flood_pkg.sv
// flood_pkg: shared types and board-setup math for
// the Flood-It core.
package flood_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    REQ,
    WAIT_READY,
    RELEASE,
    ACTIVE,
    OVER
  } state_t;

  localparam int MIN_COLORS = 3;
  localparam int MAX_COLORS = 8;
  localparam int MAX_SIZE   = 26;

  localparam int SIZE_W  = $clog2(MAX_SIZE + 1);
  localparam int COLOR_W = $clog2(MAX_COLORS + 1);
  localparam int LIM_W   = 7;

  localparam logic [SIZE_W-1:0]  SIZE_BASE = SIZE_W'(6);
  localparam logic [SIZE_W-1:0]  RST_SIZE  = SIZE_W'(14);
  localparam logic [COLOR_W-1:0] RST_COLOR = COLOR_W'(6);
  localparam logic [LIM_W-1:0]   RST_LIMIT = LIM_W'(25);

  // 0->6, 1->10, 2->14, 3->18
  function automatic logic [SIZE_W-1:0] size_of(
    input logic [1:0] sel
  );
    return SIZE_BASE + SIZE_W'({sel, 2'b00});
  endfunction

  // v -> v+3, clamped to MAX_COLORS
  function automatic logic [COLOR_W-1:0] color_of(
    input logic [2:0] sel
  );
    if (sel >= 3'(MAX_COLORS - MIN_COLORS))
      return COLOR_W'(MAX_COLORS);
    return COLOR_W'(sel) + COLOR_W'(MIN_COLORS);
  endfunction

  function automatic logic [LIM_W-1:0] limit_of(
    input logic [SIZE_W-1:0]  size,
    input logic [COLOR_W-1:0] colors
  );
    return LIM_W'(size) + LIM_W'({colors, 1'b0})
           - LIM_W'(1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop synchronizer for a single
// slow-clock-domain level.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift the async level through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/game_setup_ctrl.sv
// game_setup_ctrl: new-game sequencing, generator
// handshake and move/win/loss tracking.
module game_setup_ctrl
  import flood_pkg::*;
#(
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 1048576,
  parameter logic [15:0] DEFAULT_SEED   = 16'hDAD7
) (
  input  logic               FAST_CLOCK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [1:0]         SIZE_SEL,
  input  logic [2:0]         COLOR_SEL,
  input  logic               GEN_READY,
  input  logic               MOVE_DONE,
  input  logic               BOARD_FLOODED,
  output logic               NEW_BOARD,
  output logic [SIZE_W-1:0]  SIZE,
  output logic [COLOR_W-1:0] COLOR_NUM,
  output logic [15:0]        SEED,
  output logic [LIM_W-1:0]   MOVE_LIMIT,
  output logic [LIM_W-1:0]   MOVES_USED,
  output logic               GAME_ACTIVE,
  output logic               WON,
  output logic               LOST,
  output logic               BUSY,
  output logic               ERR_TIMEOUT
);

  localparam int TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  state_t        state, nxt;
  logic [15:0]   seed_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          rdy_s;
  logic          start_q;
  logic          start_rise;
  logic          hs;
  logic          latch_en;
  logic          won_set;
  logic          lost_set;
  logic          tmo_hit;
  logic          mv_inc;
  logic          mv_hit;

  logic [SIZE_W-1:0]  sel_size;
  logic [COLOR_W-1:0] sel_color;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_rdy_sync (
    .clk   (FAST_CLOCK),
    .rst_n (RESET_N),
    .d     (GEN_READY),
    .q     (rdy_s)
  );

  assign start_rise = START & ~start_q;
  assign hs = (state == REQ) ||
              (state == WAIT_READY) ||
              (state == RELEASE);
  assign sel_size  = size_of(SIZE_SEL);
  assign sel_color = color_of(COLOR_SEL);

  assign mv_inc = (state == ACTIVE) && MOVE_DONE &&
                  (MOVES_USED != MOVE_LIMIT);
  assign mv_hit = mv_inc &&
                  (MOVES_USED + LIM_W'(1) == MOVE_LIMIT);

  assign NEW_BOARD   = (state == REQ) ||
                       (state == WAIT_READY);
  assign BUSY        = hs;
  assign GAME_ACTIVE = (state == ACTIVE);

  // seed counter and START edge history
  always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      seed_cnt <= '0;
      start_q  <= 1'b0;
    end else begin
      seed_cnt <= seed_cnt + 16'd1;
      start_q  <= START;
    end
  end

  // state register and per-phase timeout counter
  always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= nxt;
      if (!hs || nxt != state) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // next-state and event strobes
  always_comb begin
    nxt      = state;
    latch_en = 1'b0;
    won_set  = 1'b0;
    lost_set = 1'b0;
    tmo_hit  = 1'b0;
    if (hs && tmo_cnt == TMO_LAST) begin
      tmo_hit = 1'b1;
      nxt     = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start_rise) nxt = LATCH;
        LATCH: begin
          latch_en = 1'b1;
          nxt      = REQ;
        end
        REQ: if (!rdy_s) nxt = WAIT_READY;
        WAIT_READY: if (rdy_s) nxt = RELEASE;
        RELEASE: if (!rdy_s) nxt = ACTIVE;
        ACTIVE: begin
          if (BOARD_FLOODED) begin
            won_set = 1'b1;
            nxt     = OVER;
          end else if (mv_hit) begin
            lost_set = 1'b1;
            nxt      = OVER;
          end else if (start_rise) begin
            nxt = LATCH;
          end
        end
        OVER: if (start_rise) nxt = LATCH;
        default: nxt = IDLE;
      endcase
    end
  end

  // game parameters and result flags
  always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      SIZE        <= RST_SIZE;
      COLOR_NUM   <= RST_COLOR;
      SEED        <= DEFAULT_SEED;
      MOVE_LIMIT  <= RST_LIMIT;
      MOVES_USED  <= '0;
      WON         <= 1'b0;
      LOST        <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
    end else if (latch_en) begin
      SIZE        <= sel_size;
      COLOR_NUM   <= sel_color;
      MOVE_LIMIT  <= limit_of(sel_size, sel_color);
      SEED        <= (seed_cnt == 16'd0) ?
                     DEFAULT_SEED : seed_cnt;
      MOVES_USED  <= '0;
      WON         <= 1'b0;
      LOST        <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      if (mv_inc)   MOVES_USED  <= MOVES_USED + LIM_W'(1);
      if (won_set)  WON         <= 1'b1;
      if (lost_set) LOST        <= 1'b1;
      if (tmo_hit)  ERR_TIMEOUT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_game_setup_ctrl.sv
// tb_game_setup_ctrl: randomized game sessions against
// a behavioural model of the setup controller.
module tb_game_setup_ctrl;

  localparam int SYNC = 2;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  size_sel = '0;
  logic [2:0]  color_sel = '0;
  logic        gen_ready = 1'b0;
  logic        move_done = 1'b0;
  logic        flooded = 1'b0;
  logic        new_board;
  logic [4:0]  size;
  logic [3:0]  color_num;
  logic [15:0] seed;
  logic [6:0]  move_limit;
  logic [6:0]  moves_used;
  logic        game_active;
  logic        won;
  logic        lost;
  logic        busy;
  logic        err;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc;

  int          e_lim;
  int          e_moves;
  bit          e_won;
  bit          e_lost;

  game_setup_ctrl #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO),
    .DEFAULT_SEED   (16'hDAD7)
  ) dut (
    .FAST_CLOCK    (clk),
    .RESET_N       (rst_n),
    .START         (start),
    .SIZE_SEL      (size_sel),
    .COLOR_SEL     (color_sel),
    .GEN_READY     (gen_ready),
    .MOVE_DONE     (move_done),
    .BOARD_FLOODED (flooded),
    .NEW_BOARD     (new_board),
    .SIZE          (size),
    .COLOR_NUM     (color_num),
    .SEED          (seed),
    .MOVE_LIMIT    (move_limit),
    .MOVES_USED    (moves_used),
    .GAME_ACTIVE   (game_active),
    .WON           (won),
    .LOST          (lost),
    .BUSY          (busy),
    .ERR_TIMEOUT   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".nb"},   32'(new_board),  32'd0);
    chk({tag, ".size"}, 32'(size),       32'd14);
    chk({tag, ".col"},  32'(color_num),  32'd6);
    chk({tag, ".seed"}, 32'(seed),       32'hDAD7);
    chk({tag, ".lim"},  32'(move_limit), 32'd25);
    chk({tag, ".mv"},   32'(moves_used), 32'd0);
    chk({tag, ".act"},  32'(game_active), 32'd0);
    chk({tag, ".won"},  32'(won),        32'd0);
    chk({tag, ".lost"}, 32'(lost),       32'd0);
    chk({tag, ".busy"}, 32'(busy),       32'd0);
    chk({tag, ".err"},  32'(err),        32'd0);
  endtask

  // request a game; returns with the DUT in REQ
  task automatic start_game(input int ss, input int cs);
    int e_size, e_col;
    logic [15:0] e_seed;
    size_sel  = 2'(ss);
    color_sel = 3'(cs);
    e_size = 6 + 4 * ss;
    e_col  = (cs > 5) ? 8 : cs + 3;
    e_lim  = e_size + 2 * e_col - 1;
    e_seed = 16'(cyc + 1);
    if (e_seed == 16'd0) e_seed = 16'hDAD7;
    e_moves = 0;
    e_won   = 0;
    e_lost  = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("g.size", 32'(size),       32'(e_size));
    chk("g.col",  32'(color_num),  32'(e_col));
    chk("g.lim",  32'(move_limit), 32'(e_lim));
    chk("g.seed", 32'(seed),       32'(e_seed));
    chk("g.mv",   32'(moves_used), 32'd0);
    chk("g.err",  32'(err),        32'd0);
    chk("g.won",  32'(won),        32'd0);
    chk("g.lost", 32'(lost),       32'd0);
    chk("g.nb",   32'(new_board),  32'd1);
    chk("g.busy", 32'(busy),       32'd1);
  endtask

  // generator: READY d1 cycles after request, drop
  // d2 cycles after the request is withdrawn
  task automatic handshake(input int d1, input int d2);
    int n;
    repeat (d1) tick;
    chk("hs.nb_hold", 32'(new_board), 32'd1);
    chk("hs.inact",   32'(game_active), 32'd0);
    gen_ready = 1'b1;
    n = 0;
    while (new_board && n < 20) begin
      tick;
      n++;
    end
    chk("hs.nb_fall", 32'(n), 32'(SYNC + 1));
    chk("hs.busy1",   32'(busy), 32'd1);
    repeat (d2) tick;
    chk("hs.nb_low",  32'(new_board), 32'd0);
    gen_ready = 1'b0;
    n = 0;
    while (!game_active && n < 20) begin
      tick;
      n++;
    end
    chk("hs.act_lat", 32'(n), 32'(SYNC + 1));
    chk("hs.busy0",   32'(busy), 32'd0);
  endtask

  task automatic move(input bit fl);
    move_done = 1'b1;
    flooded   = fl;
    if (!e_won && !e_lost) begin
      e_moves++;
      if (fl)                  e_won  = 1;
      else if (e_moves == e_lim) e_lost = 1;
    end
    tick;
    move_done = 1'b0;
    flooded   = 1'b0;
    chk("mv.cnt",  32'(moves_used), 32'(e_moves));
    chk("mv.won",  32'(won),        32'(e_won));
    chk("mv.lost", 32'(lost),       32'(e_lost));
    chk("mv.act",  32'(game_active),
        32'(!(e_won || e_lost)));
    repeat ($urandom_range(0, 2)) tick;
  endtask

  initial begin
    int n;
    int nm;
    int fa;

    #12;
    chk_reset("rst0");
    rst_n = 1'b1;
    repeat (3) tick;
    chk_reset("idle");

    start_game(2, 3);
    handshake(40, 40);

    repeat (26) move(1'b0);
    chk("lost.sat", 32'(moves_used), 32'd25);

    start_game(int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)));
    handshake(int'($urandom_range(2, 45)),
              int'($urandom_range(2, 45)));
    n = e_lim;
    repeat (n - 1) move(1'b0);
    move(1'b1);
    chk("flood.won",  32'(won),  32'd1);
    chk("flood.lost", 32'(lost), 32'd0);

    start_game(1, 0);
    repeat (TMO) tick;
    chk("tmo.nb_pre",  32'(new_board), 32'd1);
    chk("tmo.err_pre", 32'(err),       32'd0);
    tick;
    chk("tmo.nb",   32'(new_board), 32'd0);
    chk("tmo.err",  32'(err),       32'd1);
    chk("tmo.busy", 32'(busy),      32'd0);
    repeat (10) tick;
    chk("tmo.idle", 32'(new_board), 32'd0);
    start_game(1, 0);
    handshake(int'($urandom_range(2, 45)),
              int'($urandom_range(2, 45)));

    repeat (5) move(1'b0);
    start_game(0, 6);
    repeat (3) tick;
    chk("abort.nb", 32'(new_board), 32'd1);
    gen_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    #3;
    rst_n = 1'b1;
    repeat (3) tick;
    start_game(3, 1);
    repeat (10) tick;
    chk("stale.nb",  32'(new_board),   32'd1);
    chk("stale.act", 32'(game_active), 32'd0);
    gen_ready = 1'b0;
    handshake(int'($urandom_range(2, 45)),
              int'($urandom_range(2, 45)));

    for (int g = 0; g < 6; g++) begin
      start_game(int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)));
      handshake(int'($urandom_range(2, 45)),
                int'($urandom_range(2, 45)));
      nm = int'($urandom_range(0, e_lim + 2));
      fa = ($urandom_range(0, 1) == 1) ?
           int'($urandom_range(0, e_lim)) : -1;
      for (int i = 0; i < nm; i++) move(i == fa);
    end

    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    n = 0;
    while (cyc != 65535 && n < 70000) begin
      tick;
      n++;
    end
    chk("seed.wait", 32'(cyc), 32'd65535);
    start_game(3, 7);
    chk("seed.zero", 32'(seed),       32'hDAD7);
    chk("seed.col",  32'(color_num),  32'd8);
    chk("seed.lim",  32'(move_limit), 32'd33);
    handshake(5, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
